iter_mult_unit: RTL and testbench

//  Parametrised iterative shift-add multiplier for the pipelined CPU execute stage. Replaces the

---
 rtl/iter_mult_unit_pkg.sv | 19 +
 rtl/iter_mult_unit_if.sv | 26 ++
 rtl/iter_mult_unit_twos_neg.sv | 11 +
 rtl/iter_mult_unit.sv | 124 ++++++++++++
 tb/tb_iter_mult_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/iter_mult_unit_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// a ceiling-log2 helper used to size the iteration counter.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Never returns less than 1 so a counter is always at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iter_mult_unit_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative multiplier.
interface iter_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;

  modport master (
    output en, start, signed_mode, a, b,
    input  busy, done, product_lo, product_hi, overflow
  );

  modport slave (
    input  en, start, signed_mode, a, b,
    output busy, done, product_lo, product_hi, overflow
  );
endinterface

// File: rtl/iter_mult_unit_twos_neg.sv
// Combinational conditional two's-complement negate, shared by the operand
// magnitude path and the final sign fix.
module twos_neg #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/iter_mult_unit.sv
// Iterative shift-add multiplier: WIDTH add/shift steps on operand
// magnitudes, then one cycle to apply the sign and register the result.
module iter_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  iter_mult_unit_if.slave   bus
);
  localparam int CW = clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               sgn;
  logic               done_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               ovf_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;
  logic               ovf_next;
  logic               accept;
  logic               zero_op;

  // A pending done pulse blocks acceptance, so back-to-back starts cannot overlap it.
  assign accept  = bus.en & bus.start & (state == ST_IDLE) & ~done_q;
  assign zero_op = EARLY_ZERO && ((bus.a == '0) || (bus.b == '0));

  twos_neg #(.W(WIDTH)) u_mag_a (
    .x   (bus.a),
    .neg (bus.signed_mode & bus.a[WIDTH-1]),
    .y   (a_mag)
  );

  twos_neg #(.W(WIDTH)) u_mag_b (
    .x   (bus.b),
    .neg (bus.signed_mode & bus.b[WIDTH-1]),
    .y   (b_mag)
  );

  twos_neg #(.W(2*WIDTH)) u_fix (
    .x   ({acc, mplr}),
    .neg (neg),
    .y   (result)
  );

  assign sum      = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
  assign ovf_next = sgn ? (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}})
                        : (result[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk) begin
    if (!resetn)     state <= ST_IDLE;
    else if (bus.en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = zero_op ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mcand  <= '0;
      acc    <= '0;
      mplr   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      done_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.en) begin
      done_q <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mcand <= a_mag;
            mplr  <= zero_op ? '0 : b_mag;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            sgn   <= bus.signed_mode;
            neg   <= ~zero_op & bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        ST_CALC: begin
          // The adder carry becomes the new MSB as {carry,acc,mplr} shifts right.
          acc  <= sum[WIDTH:1];
          mplr <= {sum[0], mplr[WIDTH-1:1]};
          cnt  <= cnt - CW'(1);
        end
        ST_FIX: begin
          hi_q  <= result[2*WIDTH-1:WIDTH];
          lo_q  <= result[WIDTH-1:0];
          ovf_q <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.product_lo = lo_q;
  assign bus.product_hi = hi_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_iter_mult_unit.sv
// Drives an EARLY_ZERO=1 and an EARLY_ZERO=0 multiplier in lockstep and
// checks results, latency and handshake against a plain-arithmetic model.
module tb_iter_mult_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  iter_mult_unit_if #(.WIDTH(WIDTH)) bus_ez ();
  iter_mult_unit_if #(.WIDTH(WIDTH)) bus_fl ();

  iter_mult_unit #(.WIDTH(WIDTH), .EARLY_ZERO(1'b1)) dut_ez (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_ez.slave)
  );

  iter_mult_unit #(.WIDTH(WIDTH), .EARLY_ZERO(1'b0)) dut_fl (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_fl.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBoth(input logic en, input logic start, input logic sm,
                           input logic [31:0] a, input logic [31:0] b);
    bus_ez.en = en;  bus_ez.start = start;  bus_ez.signed_mode = sm;  bus_ez.a = a;  bus_ez.b = b;
    bus_fl.en = en;  bus_fl.start = start;  bus_fl.signed_mode = sm;  bus_fl.a = a;  bus_fl.b = b;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy_ez"}, 64'(bus_ez.busy), 0);
    checkOutput({tag, "_done_ez"}, 64'(bus_ez.done), 0);
    checkOutput({tag, "_lo_ez"},   64'(bus_ez.product_lo), 0);
    checkOutput({tag, "_hi_ez"},   64'(bus_ez.product_hi), 0);
    checkOutput({tag, "_ovf_ez"},  64'(bus_ez.overflow), 0);
    checkOutput({tag, "_busy_fl"}, 64'(bus_fl.busy), 0);
    checkOutput({tag, "_done_fl"}, 64'(bus_fl.done), 0);
    checkOutput({tag, "_lo_fl"},   64'(bus_fl.product_lo), 0);
    checkOutput({tag, "_hi_fl"},   64'(bus_fl.product_hi), 0);
    checkOutput({tag, "_ovf_fl"},  64'(bus_fl.overflow), 0);
  endtask

  // One multiply on both units; latency is counted in enabled edges after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sm,
                               input int stall_at, input int stall_len,
                               input bit junk, input bit hold);
    logic [63:0] exp_p;
    logic        exp_ovf;
    longint      sp;
    int          exp_lat_ez;
    int          act;
    int          seen_ez;
    int          seen_fl;
    bit          held;
    bit          en_now;
    if (sm) begin
      sp      = longint'($signed(a)) * longint'($signed(b));
      exp_p   = 64'(sp);
      exp_ovf = (sp > 64'sh7FFFFFFF) || (sp < -64'sh80000000);
    end else begin
      exp_p   = {32'd0, a} * {32'd0, b};
      exp_ovf = (exp_p > 64'h0000_0000_FFFF_FFFF);
    end
    exp_lat_ez = ((a == 0) || (b == 0)) ? 1 : WIDTH + 1;

    @(negedge clk);
    driveBoth(1'b1, 1'b1, sm, a, b);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_accept_ez", 64'(bus_ez.busy), 1);
    checkOutput("busy_accept_fl", 64'(bus_fl.busy), 1);

    act = 0;  seen_ez = -1;  seen_fl = -1;  held = 1'b0;
    for (int k = 1; k <= 200 && (seen_ez < 0 || seen_fl < 0); k++) begin
      en_now = !(k > stall_at && k <= stall_at + stall_len);
      if (junk && (bus_ez.busy || bus_ez.done) && (bus_fl.busy || bus_fl.done))
        driveBoth(en_now, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      else
        driveBoth(en_now, 1'b0, sm, a, b);
      @(posedge clk);
      if (en_now) act++;
      @(negedge clk);
      if (seen_ez < 0 && bus_ez.done) begin
        seen_ez = act;
        checkOutput("lo_ez",   64'(bus_ez.product_lo), 64'(exp_p[31:0]));
        checkOutput("hi_ez",   64'(bus_ez.product_hi), 64'(exp_p[63:32]));
        checkOutput("ovf_ez",  64'(bus_ez.overflow), 64'(exp_ovf));
        checkOutput("busy_done_ez", 64'(bus_ez.busy), 0);
      end
      if (seen_fl < 0 && bus_fl.done) begin
        seen_fl = act;
        checkOutput("lo_fl",   64'(bus_fl.product_lo), 64'(exp_p[31:0]));
        checkOutput("hi_fl",   64'(bus_fl.product_hi), 64'(exp_p[63:32]));
        checkOutput("ovf_fl",  64'(bus_fl.overflow), 64'(exp_ovf));
        checkOutput("busy_done_fl", 64'(bus_fl.busy), 0);
      end
    end
    checkOutput("latency_ez", 64'(seen_ez), 64'(exp_lat_ez));
    checkOutput("latency_fl", 64'(seen_fl), 64'(WIDTH + 1));

    if (hold && seen_ez == WIDTH + 1 && seen_fl == WIDTH + 1) begin
      repeat (2) begin
        driveBoth(1'b0, 1'b0, sm, a, b);
        @(posedge clk);
        @(negedge clk);
        checkOutput("done_hold_ez", 64'(bus_ez.done), 1);
        checkOutput("done_hold_fl", 64'(bus_fl.done), 1);
      end
      held = 1'b1;
    end

    driveBoth(1'b1, 1'b0, sm, a, b);
    @(posedge clk);
    @(negedge clk);
    checkOutput(held ? "done_clear_held_ez" : "done_clear_ez", 64'(bus_ez.done), 0);
    checkOutput(held ? "done_clear_held_fl" : "done_clear_fl", 64'(bus_fl.done), 0);
    checkOutput("idle_ez", 64'(bus_ez.busy), 0);
    checkOutput("idle_fl", 64'(bus_fl.busy), 0);
    checkOutput("keep_lo_ez", 64'(bus_ez.product_lo), 64'(exp_p[31:0]));
    checkOutput("keep_hi_fl", 64'(bus_fl.product_hi), 64'(exp_p[63:32]));
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_cnt;

    resetn = 1'b0;
    driveBoth(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");

    // start with en low must not be taken
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("en_low_busy_ez", 64'(bus_ez.busy), 0);
    checkOutput("en_low_busy_fl", 64'(bus_fl.busy), 0);

    $display("[TB] directed products");
    applyStimulus(32'h0000_000D, 32'h0000_000F, 1'b0, 1000, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_000D, 1'b1, 1000, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1000, 0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1000, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_1234, 1'b0, 1000, 0, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1000, 0, 1'b0, 1'b0);

    $display("[TB] stall, ignored starts and held done");
    applyStimulus(32'h1234_5678, 32'h0000_9ABC, 1'b0, 10, 5, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FF00, 32'h0000_0100, 1'b1, 3, 2, 1'b1, 1'b1);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(2, 25),
                    $urandom_range(0, 4), 1'b1, 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] reset during calculation");
    @(negedge clk);
    driveBoth(1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'h0001_0003);
    @(posedge clk);
    @(negedge clk);
    driveBoth(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0001_0003);
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checkIdleZero("abort");
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_ez.done || bus_fl.done) done_cnt++;
    end
    checkOutput("abort_no_done", 64'(done_cnt), 0);
    applyStimulus(32'h0000_0077, 32'h0001_0003, 1'b0, 1000, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
